// File: rtl/ssd_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package ssd_pkg;

    localparam int unsigned DIGITS = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DATA_W = DIGITS * NIB_W;

    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF    = 8'hFF;

    // Active-low segment patterns, bit order g..a, indexed by hex value.
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0011000;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DIGITS-1:0] dp;
        logic [DIGITS-1:0] en;
    } disp_set_t;

endpackage

// File: rtl/ssd_scan_if.sv
// Display bus: host-side load of digit data, scanner-side anode/segment drive.
interface ssd_scan_if;
    import ssd_pkg::*;

    logic [DATA_W-1:0] data;
    logic [DIGITS-1:0] dp;
    logic [DIGITS-1:0] en;
    logic              load;
    logic [DIGITS-1:0] an;
    logic [SEG_W-1:0]  cc;
    logic              odp;
    logic              frame;

    modport master (output data, dp, en, load, input an, cc, odp, frame);
    modport slave  (input data, dp, en, load, output an, cc, odp, frame);

endinterface

// File: rtl/ssd_seg_enc.sv
// Hex nibble to active-low seven-segment pattern (combinational).
module ssd_seg_enc
    import ssd_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [SEG_W-1:0] seg_c_o
);

    assign seg_c_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/ssd_scan.sv
// Eight-digit time-multiplexed seven-segment scanner with shadow/active
// double buffering so a displayed frame is never torn by a host load.
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 1000
) (
    input  logic       ssd_scan_port_clk,
    input  logic       ssd_scan_port_rst,
    ssd_scan_if.slave  ssd_scan_port
);

    localparam int unsigned      CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_q, pend_d;
    disp_set_t         shadow_q, shadow_d;
    disp_set_t         active_q, active_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]  cc_q, cc_d;
    logic              odp_q, odp_d;
    logic              frame_q, frame_d;

    logic              term_c;
    logic              wrap_c;
    logic              lit_c;
    logic [NIB_W-1:0]  nib_c;
    logic [SEG_W-1:0]  seg_c;
    disp_set_t         in_set_c;

    ssd_seg_enc u_seg_enc (
        .nib_i   (nib_c),
        .seg_c_o (seg_c)
    );

    // Next-state: prescaler, slot index, buffer handoff and output drive.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        shadow_d = shadow_q;
        active_d = active_q;

        in_set_c.data = ssd_scan_port.data;
        in_set_c.dp   = ssd_scan_port.dp;
        in_set_c.en   = ssd_scan_port.en;

        term_c = (cnt_q == CNT_LAST);
        wrap_c = term_c && (idx_q == IDX_LAST);

        if (term_c) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A load landing on the wrap goes straight to the new frame.
        if (ssd_scan_port.load && wrap_c) begin
            active_d = in_set_c;
            pend_d   = 1'b0;
        end else if (ssd_scan_port.load) begin
            shadow_d = in_set_c;
            pend_d   = 1'b1;
        end else if (wrap_c && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end

        nib_c = active_q.data[{idx_q, 2'b00} +: NIB_W];
        lit_c = active_q.en[idx_q] && (32'(cnt_q) >= BLANK_CYC);

        an_d    = AN_OFF;
        cc_d    = SEG_BLANK;
        odp_d   = 1'b1;
        frame_d = wrap_c;
        if (lit_c) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            cc_d  = seg_c;
            odp_d = ~active_q.dp[idx_q];
        end
    end

    always_ff @(posedge ssd_scan_port_clk) begin
        if (ssd_scan_port_rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            an_q     <= AN_OFF;
            cc_q     <= SEG_BLANK;
            odp_q    <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            an_q     <= an_d;
            cc_q     <= cc_d;
            odp_q    <= odp_d;
            frame_q  <= frame_d;
        end
    end

    assign ssd_scan_port.an    = an_q;
    assign ssd_scan_port.cc    = cc_q;
    assign ssd_scan_port.odp   = odp_q;
    assign ssd_scan_port.frame = frame_q;

endmodule

// File: doc/ssd_scan.md
SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range >= 2.
REQ-002 Parameter BLANK_CYC, default 1000, anti-ghost blank cycles at the start of each slot; legal range 0 to REFRESH_DIV-1.
REQ-003 ssd_scan_port_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 ssd_scan_port_rst  in  1  reset, synchronous, active-high.
REQ-005 ssd_scan_port_data  in  32  eight hex nibbles; nibble k (bits 4k+3:4k) feeds digit k.
REQ-006 ssd_scan_port_dp  in  8  per-digit decimal point; 1 = lit.
REQ-007 ssd_scan_port_en  in  8  per-digit enable; 0 = digit blank.
REQ-008 ssd_scan_port_load  in  1  one-cycle strobe that captures data, dp and en into the shadow set.
REQ-009 ssd_scan_port_an  out  8  anode selects, active-low, at most one bit low.
REQ-010 ssd_scan_port_cc  out  7  segments g..a, active-low.
REQ-011 ssd_scan_port_odp  out  1  decimal point, active-low.
REQ-012 ssd_scan_port_frame  out  1  one-cycle pulse marking the start of each frame.

Function
REQ-013 Prescaler cnt counts 0..REFRESH_DIV-1; on terminal count it returns to 0 and slot index idx advances by 1; idx 7 wraps to 0 (wrap cycle).
REQ-014 Two register sets are held: shadow and active, each containing data[31:0], dp[7:0] and en[7:0].
REQ-015 load writes the shadow set and sets pending; a later load before the next wrap overwrites the shadow set.
REQ-016 On a wrap cycle with pending=1, shadow is copied to active and pending clears.
REQ-017 load asserted on a wrap cycle bypasses the shadow: the inputs go straight to active, pending clears, and the values apply from slot 0 of the new frame.
REQ-018 Active values never change except per REQ-016 or REQ-017, so a frame is never torn.
REQ-019 All outputs are registered; outputs in cycle t+1 reflect cnt, idx and active in cycle t.
REQ-020 an = ~(1<<idx) when en[idx]=1 and cnt >= BLANK_CYC; otherwise an = 8'hFF.
REQ-021 cc = hex encoding of the active nibble idx: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-022 When an = 8'hFF: cc = 7'h7F and odp = 1; otherwise odp = ~dp[idx].
REQ-023 frame = 1 for exactly one cycle: the cycle following each wrap cycle, i.e. alongside the first outputs of slot 0.
REQ-024 Counter width = $clog2(REFRESH_DIV); no overflow path exists.

Reset
REQ-025 While rst=1 at a clock edge: cnt=0, idx=0, pending=0, shadow=0, active=0, an=8'hFF, cc=7'h7F, odp=1, frame=0.
REQ-026 Reset asserted mid-slot or mid-frame aborts the scan; after release, the scan restarts at slot 0, cnt 0, with all digits blank until a load completes.
REQ-027 frame is not pulsed on reset release; the first frame pulse follows the first wrap.

Structure
REQ-028 Package ssd_pkg holds the 16-entry segment table constants, SEG_BLANK = 7'h7F and AN_OFF = 8'hFF.
REQ-029 One sub-module ssd_seg_enc (4-bit nibble to 7-bit segments, purely combinational, uses ssd_pkg) is instantiated once.

Verification
REQ-030 Bench parameters REFRESH_DIV=4, BLANK_CYC=1; all expected values below use them.
REQ-031 Reset: rst=1 for 3 cycles -> an=FF, cc=7F, odp=1, frame=0 every cycle; after release, an stays FF because active en=0.
REQ-032 Load data=32'h76543210, en=FF, dp=01 mid-frame -> no change until frame pulse; then slot 0 shows cycle 1 an=FF, cycles 2-4 an=FE, cc=1000000, odp=0; slot 1 an=FD, cc=1111001, odp=1; slot 7 an=7F, cc=1111000.
REQ-033 en=FE loaded -> slot 0 an=FF, cc=7F for all 4 cycles; slots 1-7 unaffected.
REQ-034 Second load with data=32'hFFFFFFFF in slot 3 -> slots 3-7 still show 3..7; the next frame shows 0001110 on all digits.
REQ-035 Load data=32'hAAAAAAAA on the wrap cycle -> slot 0 of the immediately following frame shows cc=0001000; pending=0.
REQ-036 rst pulsed during slot 5 -> next cycle reset values per REQ-025; after release, no frame pulse until 32 cycles later, scan from slot 0.
